spi_reg_rx: RTL and testbench

SPI_REG_RX -- requirements
Module: spi_reg_rx

---
 rtl/spi_reg_rx.sv | 262 ++++++++++++++++++++++++++
 tb/tb_spi_reg_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_rx.sv
// -----------------------------------------------------------------------------
// spi_reg_rx
// -----------------------------------------------------------------------------
// SPI slave receiver that captures one fixed-length register write per frame.
// A frame is DATA_W data bits followed by ADDR_W address bits, both MSB-first,
// transferred while SS is low. SCLK, MOSI and SS are asynchronous to CLK. They
// are oversampled through SYNC_STAGES-deep synchronisers, and all SPI edges are
// detected in the CLK domain.
//
// A frame is accepted only if exactly DATA_W+ADDR_W sampling edges occurred
// while SS was low. An accepted frame updates SPI_DATA/SPI_ADDRESS and pulses
// SPI_ENA. Any other bit count pulses SPI_ERR and leaves the outputs untouched.
// A frame that is already in progress when reset is released is dropped
// without a strobe (LOCKOUT state).
//
// Optional feature (compile-time macro SPI_REG_RX_READBACK_EN):
//   On SS fall, {SPI_DATA,SPI_ADDRESS} is copied into a transmit register.
//   Its MSB drives MISO, and it shifts left on every non-sampling SCLK edge.
//   When the macro is undefined, MISO is tied low and no transmit register
//   exists.
//
// Parameters
//   DATA_W       data field width (1..32)
//   ADDR_W       address field width (1..32)
//   SAMPLE_EDGE  1: sample MOSI on SCLK rise, 0: on SCLK fall
//   SYNC_STAGES  synchroniser depth (2..4)
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous active-low reset
//   SCLK         SPI clock (async)
//   MOSI         SPI data in (async)
//   SS           active-low frame select (async)
//   MISO         readback serial data (0 without readback)
//   SPI_DATA     data field of last valid frame
//   SPI_ADDRESS  address field of last valid frame
//   SPI_ENA      one-cycle strobe, new valid frame
//   SPI_ERR      one-cycle strobe, frame dropped for wrong bit count
// -----------------------------------------------------------------------------
module spi_reg_rx #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int SAMPLE_EDGE = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              SS,
  output logic              MISO,
  output logic [DATA_W-1:0] SPI_DATA,
  output logic [ADDR_W-1:0] SPI_ADDRESS,
  output logic              SPI_ENA,
  output logic              SPI_ERR
);

  localparam int FRAME_W = DATA_W + ADDR_W;
  // The counter must reach FRAME_W+1 so that over-long frames stay
  // distinguishable from exact ones.
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic                   sclk_prev_q;
  logic                   ss_prev_q;

  // Synchroniser chains plus one-cycle history for edge detection.
  // SS clears to 0, so after reset the block sees SS as low. A released-high
  // SS therefore shows up as a rising edge that takes LOCKOUT to IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      ss_sync_q   <= {SYNC_STAGES{1'b0}};
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic mosi_s;
  logic ss_s;
  logic sclk_rise_s;
  logic sclk_fall_s;
  logic ss_rise_s;
  logic ss_fall_s;
  logic sample_edge_s;

  assign sclk_s        = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s        = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s          = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s   = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s   = ~sclk_s & sclk_prev_q;
  assign ss_rise_s     = ss_s & ~ss_prev_q;
  assign ss_fall_s     = ~ss_s & ss_prev_q;
  assign sample_edge_s = (SAMPLE_EDGE != 0) ? sclk_rise_s : sclk_fall_s;

  // ---------------------------------------------------------------------------
  // Frame FSM and output registers
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ena_q, ena_d;
  logic                err_q, err_d;

  // Next-state logic. Strobes default low, so each lasts exactly one cycle.
  // Data and address change only on an accepted frame, so partial shift
  // contents never reach the outputs.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    ena_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall_s) begin
          state_d = ST_SHIFT;
          shift_d = {FRAME_W{1'b0}};
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ss_rise_s) begin
          state_d = ST_IDLE;
          if (cnt_q == CNT_FULL) begin
            data_d = shift_q[FRAME_W-1 -: DATA_W];
            addr_d = shift_q[ADDR_W-1:0];
            ena_d  = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end else if (sample_edge_s) begin
          shift_d = {shift_q[FRAME_W-2:0], mosi_s};
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_LOCKOUT: begin
        // A frame cut by reset ends silently.
        if (ss_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKOUT;
        end
      end
      default: begin
        // Unreachable encoding: recover to a safe state that matches SS.
        state_d = ss_s ? ST_IDLE : ST_LOCKOUT;
      end
    endcase
  end

  // State, shift register, counter and registered outputs.
  // Reset lands in LOCKOUT because the synchronised SS is cleared low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_LOCKOUT;
      shift_q <= {FRAME_W{1'b0}};
      cnt_q   <= CNT_ZERO;
      data_q  <= {DATA_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      ena_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      ena_q   <= ena_d;
      err_q   <= err_d;
    end
  end

  assign SPI_DATA    = data_q;
  assign SPI_ADDRESS = addr_q;
  assign SPI_ENA     = ena_q;
  assign SPI_ERR     = err_q;

  // ---------------------------------------------------------------------------
  // Optional readback path
  // ---------------------------------------------------------------------------
`ifdef SPI_REG_RX_READBACK_EN
  logic               drive_edge_s;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic               miso_q, miso_d;

  // MISO changes on the edge opposite the sampling edge, so the master sees
  // it stable at its own sampling edge.
  assign drive_edge_s = (SAMPLE_EDGE != 0) ? sclk_fall_s : sclk_rise_s;

  // Transmit register: load the last accepted frame at frame start, then
  // shift on every drive edge. MISO is forced low whenever no frame is
  // being shifted.
  always_comb begin
    tx_d = tx_q;
    if ((state_q == ST_IDLE) && ss_fall_s) begin
      tx_d = {data_q, addr_q};
    end else if ((state_q == ST_SHIFT) && !ss_rise_s && drive_edge_s) begin
      tx_d = {tx_q[FRAME_W-2:0], 1'b0};
    end else begin
      tx_d = tx_q;
    end
    if (state_d == ST_SHIFT) begin
      miso_d = tx_d[FRAME_W-1];
    end else begin
      miso_d = 1'b0;
    end
  end

  // Transmit register and registered MISO.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_q   <= {FRAME_W{1'b0}};
      miso_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      miso_q <= miso_d;
    end
  end

  assign MISO = miso_q;
`else
  assign MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_rx.sv
module tb_spi_reg_rx;

  localparam int H = 8;  // SCLK half period in CLK cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk0, mosi0, ss0, miso0, ena0, err0;
  logic [7:0] data0, addr0;
  logic       sclk1, mosi1, ss1, miso1, ena1, err1;
  logic [7:0] data1, addr1;

  always #5 clk = ~clk;

  spi_reg_rx #(.DATA_W(8), .ADDR_W(8), .SAMPLE_EDGE(1), .SYNC_STAGES(2)) dut0 (
    .CLK(clk), .RST(rst_n), .SCLK(sclk0), .MOSI(mosi0), .SS(ss0), .MISO(miso0),
    .SPI_DATA(data0), .SPI_ADDRESS(addr0), .SPI_ENA(ena0), .SPI_ERR(err0));

  spi_reg_rx #(.DATA_W(8), .ADDR_W(8), .SAMPLE_EDGE(0), .SYNC_STAGES(2)) dut1 (
    .CLK(clk), .RST(rst_n), .SCLK(sclk1), .MOSI(mosi1), .SS(ss1), .MISO(miso1),
    .SPI_DATA(data1), .SPI_ADDRESS(addr1), .SPI_ENA(ena1), .SPI_ERR(err1));

  typedef struct {
    int          nbits;
    logic [31:0] bits;
    logic        exp_ena;
    logic        exp_err;
    logic [7:0]  exp_data;
    logic [7:0]  exp_addr;
  } vec_t;

  typedef struct {
    logic       ena;
    logic       err;
    logic [7:0] d;
    logic [7:0] a;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_valid = 16'h0000;  // readback model: last accepted frame

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic ena, input logic err, input logic [7:0] d, input logic [7:0] a);
    exp_t e;
    e.ena = ena; e.err = err; e.d = d; e.a = a;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor for dut0: every strobe cycle pops one expectation.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst_n && (ena0 || err0)) begin
      chk("ena_err_exclusive", 32'(ena0 & err0), 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual ena=%0b err=%0b expected none", ena0, err0);
      end else begin
        e = sb_q.pop_front();
        chk("strobe_ena", 32'(ena0), 32'(e.ena));
        chk("strobe_err", 32'(err0), 32'(e.err));
        chk("spi_data", 32'(data0), 32'(e.d));
        chk("spi_address", 32'(addr0), 32'(e.a));
      end
    end
  end

  // Drive bits MSB-first on dut0 (mode: change while SCLK low, sample on rise).
  task automatic bits0(input int nbits, input logic [31:0] bits, input bit chk_miso);
    logic exp_b;
    int   k;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi0 = bits[i];
      repeat (H) @(negedge clk);
      k = nbits - 1 - i;
`ifdef SPI_REG_RX_READBACK_EN
      exp_b = (k < 16) ? last_valid[15-k] : 1'b0;
`else
      exp_b = 1'b0;
`endif
      if (chk_miso) chk("miso_bit", 32'(miso0), 32'(exp_b));
      sclk0 = 1'b1;
      repeat (H) @(negedge clk);
      if (chk_miso) chk("miso_stable", 32'(miso0), 32'(exp_b));
      sclk0 = 1'b0;
    end
  endtask

  task automatic frame0(input int nbits, input logic [31:0] bits, input int gap);
    ss0 = 1'b0;
    repeat (H) @(negedge clk);
    bits0(nbits, bits, 1'b1);
    repeat (H) @(negedge clk);
    ss0 = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  vec_t tbl[9];
  int   ena1_cnt;
  int   err1_cnt;
  logic [15:0] w1;

  initial begin
    tbl[0] = '{16, 32'h0000A53C, 1'b1, 1'b0, 8'hA5, 8'h3C};
    tbl[1] = '{16, 32'h00001122, 1'b1, 1'b0, 8'h11, 8'h22};
    tbl[2] = '{15, 32'h00001234, 1'b0, 1'b1, 8'h11, 8'h22};
    tbl[3] = '{17, 32'h0001ABCD, 1'b0, 1'b1, 8'h11, 8'h22};
    tbl[4] = '{0,  32'h00000000, 1'b0, 1'b1, 8'h11, 8'h22};
    tbl[5] = '{16, 32'h0000FFFF, 1'b1, 1'b0, 8'hFF, 8'hFF};
    tbl[6] = '{16, 32'h00000000, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[7] = '{16, 32'h0000A53C, 1'b1, 1'b0, 8'hA5, 8'h3C};
    tbl[8] = '{16, 32'h00005AC3, 1'b1, 1'b0, 8'h5A, 8'hC3};

    rst_n = 1'b0;
    sclk0 = 1'b0; mosi0 = 1'b0; ss0 = 1'b1;
    sclk1 = 1'b0; mosi1 = 1'b0; ss1 = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_data", 32'(data0), 32'd0);
    chk("reset_addr", 32'(addr0), 32'd0);
    chk("reset_ena", 32'(ena0), 32'd0);
    chk("reset_err", 32'(err0), 32'd0);
    chk("reset_miso", 32'(miso0), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Table of frames on dut0.
    for (int v = 0; v < 9; v++) begin
      if (tbl[v].exp_ena || tbl[v].exp_err)
        push_exp(tbl[v].exp_ena, tbl[v].exp_err, tbl[v].exp_data, tbl[v].exp_addr);
      chk("miso_idle", 32'(miso0), 32'd0);
      frame0(tbl[v].nbits, tbl[v].bits, 20);
      wait_drain();
      if (tbl[v].exp_ena) last_valid = {tbl[v].exp_data, tbl[v].exp_addr};
    end

    // Reset in mid-frame, released with SS low: the remainder is dropped.
    ss0 = 1'b0;
    repeat (H) @(negedge clk);
    bits0(7, 32'h00000055, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_data", 32'(data0), 32'd0);
    chk("midreset_addr", 32'(addr0), 32'd0);
    chk("midreset_miso", 32'(miso0), 32'd0);
    rst_n = 1'b1;
    repeat (H) @(negedge clk);
    bits0(9, 32'h000001FF, 1'b0);
    repeat (H) @(negedge clk);
    ss0 = 1'b1;
    repeat (30) @(negedge clk);
    chk("lockout_data_hold", 32'(data0), 32'd0);
    last_valid = 16'h0000;
    push_exp(1'b1, 1'b0, 8'h0F, 8'hF0);
    frame0(16, 32'h00000FF0, 20);
    wait_drain();
    last_valid = 16'h0FF0;

    // Two frames separated by only 4 cycles of SS high.
    push_exp(1'b1, 1'b0, 8'h12, 8'h34);
    push_exp(1'b1, 1'b0, 8'h56, 8'h78);
    frame0(16, 32'h00001234, 4);
    last_valid = 16'h1234;
    frame0(16, 32'h00005678, 20);
    wait_drain();
    last_valid = 16'h5678;

    // SCLK edges with SS high are ignored.
    for (int i = 0; i < 5; i++) begin
      sclk0 = 1'b1; repeat (H) @(negedge clk);
      sclk0 = 1'b0; repeat (H) @(negedge clk);
    end
    chk("ss_high_hold_data", 32'(data0), 32'h56);
    chk("ss_high_hold_addr", 32'(addr0), 32'h78);

    // dut1 samples on the falling edge; MOSI changes on the rising edge.
    w1 = 16'hC381;
    ena1_cnt = 0;
    err1_cnt = 0;
    ss1 = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 15; i >= 0; i--) begin
      sclk1 = 1'b1;
      mosi1 = w1[i];
      repeat (H) @(negedge clk);
      sclk1 = 1'b0;
      repeat (H) @(negedge clk);
    end
    ss1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ena1) ena1_cnt++;
      if (err1) err1_cnt++;
    end
    chk("fall_edge_ena_count", 32'(ena1_cnt), 32'd1);
    chk("fall_edge_err_count", 32'(err1_cnt), 32'd0);
    chk("fall_edge_data", 32'(data1), 32'hC3);
    chk("fall_edge_addr", 32'(addr1), 32'h81);

    chk("scoreboard_final", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
